iic_rd_byte_ack: RTL
====================

// Module: iic_rd_byte_ack
// PURPOSE
// - Master-side IIC read-byte receiver with acknowledge generation, the counterpart of the write-ack checker.
// - Shifts NBITS data bits from the slave on SDA, MSB first, then drives ACK (SDA=0), or NACK (SDA=1) on the last byte, in the 9th SCL period.
// - Sits under the IIC controller FSM next to the SCL phase generator, which supplies the strobes.
// - The controller owns the SDA pad through sdalink/sda_out.
// PARAMETERS
// - NBITS  8  data bits per byte; legal range 1..16
// PORTS
// - clk        in   1      system clock (100 MHz)
// - rst        in   1      asynchronous reset, active-high
// - start      in   1      1-cycle pulse: begin receiving a byte; ignored unless idle
// - last       in   1      sampled with start; 1 = answer NACK (final byte), 0 = ACK
// - abort      in   1      synchronous abort to IDLE; releases SDA, no done pulse
// - scl_hc     in   1      1-cycle strobe at SCL-high midpoint (sample point)
// - scl_lc     in   1      1-cycle strobe at SCL-low midpoint (SDA change point)
// - sda_in     in   1      SDA pad input
// - sda_out    out  1      SDA value driven when sdalink=1
// - sdalink    out  1      SDA output enable; 1 = master drives SDA
// - data_out   out  NBITS  received byte; valid from done, held until next start
// - busy       out  1      high from the cycle after an accepted start until done/abort
// - done       out  1      1-cycle pulse: byte received and ACK/NACK bit completed
// BEHAVIOUR
// - Reset: state=IDLE; sda_out=1, sdalink=0, data_out=0, busy=0, done=0; bit counter=0, last latch=0.
// - IDLE:
//   - start=1 -> latch last, clear counter and shift register, busy=1, go to SHIFT.
//   - sdalink stays 0.
// - SHIFT:
//   - sdalink=0.
//   - Each scl_hc: shift register <= {sr[NBITS-2:0], sda_in}; counter++.
//   - When the NBITS-th sample is taken -> ACK_SETUP.
//   - scl_lc is ignored in SHIFT.
// - ACK_SETUP:
//   - Wait for scl_lc.
//   - On scl_lc: sdalink<=1, sda_out<=last_q -> ACK_HOLD.
//   - SDA therefore changes only while SCL is low.
// - ACK_HOLD:
//   - Drive SDA through the next scl_hc.
//   - On the first scl_lc after that scl_hc: sdalink<=0, sda_out<=1, data_out<=sr, done<=1 for 1 cycle, busy<=0 -> IDLE.
//   - Total: done fires on the 10th scl_lc edge counted from the cycle after start (NBITS=8).
// - abort: in any state, abort takes priority over all strobes.
//   - Next cycle: IDLE, sdalink=0, sda_out=1, busy=0, done=0.
//   - data_out keeps its previous value.
// - start while busy: ignored; last is not re-latched.
// - start and abort in the same cycle in IDLE: abort wins, start is dropped.
// - scl_hc and scl_lc in the same cycle: a protocol error from the generator.
//   - scl_hc is processed, scl_lc is dropped.
// - Strobes in IDLE: no effect.
// - Reset mid-byte: immediate release of SDA (sdalink=0), no done pulse.
// - Counter width: $clog2(NBITS+1); it is not allowed to wrap.
// STRUCTURE
// - Shared package/include iic_defs.vh: state encodings IIC_RX_IDLE=2'd0, IIC_RX_SHIFT=2'd1, IIC_RX_ACKS=2'd2, IIC_RX_ACKH=2'd3; IIC_ACK=1'b0, IIC_NACK=1'b1.
// - Single module; no sub-module needed.
// - All outputs are registered.
// TESTING
// - Bench model: the slave drives sda_in only between scl_lc strobes; the SCL phase generator is modelled with scl_hc/scl_lc 250 cycles apart.
// - Byte 8'hA5, last=0 -> data_out=8'hA5; sdalink=1 with sda_out=0 across exactly one scl_hc; done pulses once; busy falls with done.
// - Byte 8'h3C, last=1 -> sda_out=1 during the ACK bit; data_out=8'h3C; done pulses once.
// - Back-to-back bytes 8'hFF then 8'h00 (start in the cycle after done) -> both captured correctly; no SDA drive during data bits.
// - abort after the 4th scl_hc -> sdalink=0 the next cycle, no done, data_out unchanged.
//   - A following start/8'h81 then succeeds.
// - rst asserted during ACK_HOLD -> sdalink=0 and busy=0 immediately, without waiting for a clock edge; start ignored while busy (second start mid-byte leaves last_q unchanged).
// - NBITS=16, word 16'hBEEF, last=1 -> data_out=16'hBEEF; NACK driven; done fires after 18 scl_lc strobes.

Source files
------------

// File: rtl/iic_rd_byte_ack_pkg.sv
// Shared definitions for the IIC master-side read-byte receiver:
// receiver state encodings and the ACK/NACK bit levels.
package iic_rd_byte_ack_pkg;

  typedef enum logic [1:0] {
    IIC_RX_IDLE  = 2'd0,
    IIC_RX_SHIFT = 2'd1,
    IIC_RX_ACKS  = 2'd2,
    IIC_RX_ACKH  = 2'd3
  } iic_rx_state_t;

  localparam logic IIC_ACK  = 1'b0;
  localparam logic IIC_NACK = 1'b1;

  // The final byte of a read is answered with NACK so the slave releases SDA.
  function automatic logic ack_bit(input logic is_last);
    return is_last ? IIC_NACK : IIC_ACK;
  endfunction

endpackage

// File: rtl/iic_rd_byte_ack_if.sv
// Bus bundle between the IIC controller (master modport) and the
// read-byte receiver (slave modport).
interface iic_rd_byte_ack_if #(
  parameter int NBITS = 8
);

  logic             start;
  logic             last;
  logic             abort;
  logic             scl_hc;
  logic             scl_lc;
  logic             sda_in;
  logic             sda_out;
  logic             sdalink;
  logic [NBITS-1:0] data_out;
  logic             busy;
  logic             done;

  modport master (
    output start, last, abort, scl_hc, scl_lc, sda_in,
    input  sda_out, sdalink, data_out, busy, done
  );

  modport slave (
    input  start, last, abort, scl_hc, scl_lc, sda_in,
    output sda_out, sdalink, data_out, busy, done
  );

endinterface

// File: rtl/iic_rd_byte_ack.sv
// IIC master-side read-byte receiver: shifts NBITS bits in MSB first on
// scl_hc, then drives ACK/NACK for one SCL period, changing SDA only on scl_lc.
module iic_rd_byte_ack
  import iic_rd_byte_ack_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  iic_rd_byte_ack_if.slave  bus
);

  localparam int            CW       = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NBITS - 1);

  iic_rx_state_t    state_q,    state_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [NBITS-1:0] sr_q,       sr_d;
  logic             last_q,     last_d;
  logic             sda_out_q,  sda_out_d;
  logic             sdalink_q,  sdalink_d;
  logic [NBITS-1:0] data_out_q, data_out_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             hc_seen_q,  hc_seen_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IIC_RX_IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      last_q     <= 1'b0;
      sda_out_q  <= 1'b1;
      sdalink_q  <= 1'b0;
      data_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hc_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      last_q     <= last_d;
      sda_out_q  <= sda_out_d;
      sdalink_q  <= sdalink_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hc_seen_q  <= hc_seen_d;
    end
  end

  // Abort overrides every strobe; within a state scl_hc wins over a
  // simultaneous scl_lc, so the lc branches are only reached without hc.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    last_d     = last_q;
    sda_out_d  = sda_out_q;
    sdalink_d  = sdalink_q;
    data_out_d = data_out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hc_seen_d  = hc_seen_q;

    if (bus.abort) begin
      state_d   = IIC_RX_IDLE;
      sdalink_d = 1'b0;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
      hc_seen_d = 1'b0;
    end else begin
      case (state_q)
        IIC_RX_IDLE: begin
          sdalink_d = 1'b0;
          if (bus.start) begin
            last_d    = bus.last;
            cnt_d     = '0;
            sr_d      = '0;
            busy_d    = 1'b1;
            hc_seen_d = 1'b0;
            state_d   = IIC_RX_SHIFT;
          end
        end

        IIC_RX_SHIFT: begin
          sdalink_d = 1'b0;
          if (bus.scl_hc) begin
            sr_d    = sr_q << 1;
            sr_d[0] = bus.sda_in;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) begin
              state_d = IIC_RX_ACKS;
            end
          end
        end

        IIC_RX_ACKS: begin
          if (!bus.scl_hc && bus.scl_lc) begin
            sdalink_d = 1'b1;
            sda_out_d = ack_bit(last_q);
            hc_seen_d = 1'b0;
            state_d   = IIC_RX_ACKH;
          end
        end

        IIC_RX_ACKH: begin
          // Release only on the low phase that follows the slave's sample.
          if (bus.scl_hc) begin
            hc_seen_d = 1'b1;
          end else if (bus.scl_lc && hc_seen_q) begin
            sdalink_d  = 1'b0;
            sda_out_d  = 1'b1;
            data_out_d = sr_q;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            hc_seen_d  = 1'b0;
            state_d    = IIC_RX_IDLE;
          end
        end

        default: begin
          state_d = IIC_RX_IDLE;
        end
      endcase
    end
  end

  assign bus.sda_out  = sda_out_q;
  assign bus.sdalink  = sdalink_q;
  assign bus.data_out = data_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
